// File: rtl/ahb_ml_mac_acc.sv
// AHB-Lite dot-product accelerator: two signed operand vectors and a
// one-MAC-per-cycle engine with status flags, sticky overflow and IRQ.
module ahb_ml_mac_acc #(
  parameter int DATA_W  = 16,
  parameter int VEC_LEN = 8,
  parameter int ACC_W   = 40
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic        HREADY,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP,
  output logic [31:0] HRDATA,
  output logic        IRQ
);

  localparam int LW = 5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIN
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [7:0]  addr_q;
  logic        wr_q;
  logic        rd_q;
  logic        sel;

  logic signed [DATA_W-1:0] x_q [VEC_LEN];
  logic signed [DATA_W-1:0] w_q [VEC_LEN];
  logic [LW-1:0]            len_q;
  logic [LW-1:0]            idx_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic                     ie_q;
  logic                     done_q;
  logic                     ovf_q;

  logic        busy;
  logic        mac_en;
  logic        fin;

  logic        a_ctrl;
  logic        a_len;
  logic        a_lo;
  logic        a_hi;
  logic        a_x;
  logic        a_w;
  logic        e_ok;
  logic [LW-1:0] eidx;

  logic        ctrl_we;
  logic        start_go;
  logic        clear_go;
  logic        last;
  logic [LW-1:0] len_wr;

  logic signed [DATA_W-1:0]   x_sel;
  logic signed [DATA_W-1:0]   w_sel;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    sum;
  logic                       ovf_now;

  logic signed [DATA_W-1:0] rx;
  logic signed [DATA_W-1:0] rw;
  logic signed [63:0]       acc64;
  logic [31:0]              rdata;

  logic unused_ok;

  assign HREADYOUT = 1'b1;
  assign HRESP     = 2'b00;
  assign IRQ       = done_q & ie_q;
  assign unused_ok = ^{HSIZE, HTRANS[0], HADDR[31:8]};

  assign sel = HSEL & HREADY & HTRANS[1];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_q <= '0;
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
    end else begin
      wr_q <= sel & HWRITE;
      rd_q <= sel & ~HWRITE;
      if (sel)
        addr_q <= HADDR[7:0];
    end
  end

  // Decode from the latched address; shared by write and read paths
  assign eidx   = {1'b0, addr_q[5:2]};
  assign e_ok   = (addr_q[1:0] == 2'b00) &&
                  (eidx < LW'(VEC_LEN));
  assign a_ctrl = (addr_q == 8'h00);
  assign a_len  = (addr_q == 8'h04);
  assign a_lo   = (addr_q == 8'h08);
  assign a_hi   = (addr_q == 8'h0C);
  assign a_x    = (addr_q[7:6] == 2'b01) && e_ok;
  assign a_w    = (addr_q[7:6] == 2'b10) && e_ok;

  assign ctrl_we  = wr_q & a_ctrl;
  assign clear_go = ctrl_we & HWDATA[1];
  assign start_go = ctrl_we & HWDATA[0] &
                    ~HWDATA[1] & ~busy;

  assign len_wr = (HWDATA > 32'(VEC_LEN)) ?
                  LW'(VEC_LEN) : HWDATA[LW-1:0];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < VEC_LEN; i++) begin
        x_q[i] <= '0;
        w_q[i] <= '0;
      end
      len_q <= '0;
      ie_q  <= 1'b0;
    end else begin
      for (int i = 0; i < VEC_LEN; i++) begin
        if (wr_q & a_x & ~busy & (eidx == LW'(i)))
          x_q[i] <= HWDATA[DATA_W-1:0];
        if (wr_q & a_w & ~busy & (eidx == LW'(i)))
          w_q[i] <= HWDATA[DATA_W-1:0];
      end
      if (wr_q & a_len & ~busy)
        len_q <= len_wr;
      if (ctrl_we)
        ie_q <= HWDATA[2];
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  assign last = ((idx_q + LW'(1)) == len_q);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_go)
          state_d = (len_q == '0) ? S_FIN : S_RUN;
      end
      S_RUN: begin
        if (last)
          state_d = S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (clear_go)
      state_d = S_IDLE;
  end

  always_comb begin
    busy   = 1'b0;
    mac_en = 1'b0;
    fin    = 1'b0;
    unique case (state_q)
      S_RUN: begin
        busy   = 1'b1;
        mac_en = 1'b1;
      end
      S_FIN: begin
        busy = 1'b1;
        fin  = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    x_sel = '0;
    w_sel = '0;
    for (int i = 0; i < VEC_LEN; i++) begin
      if (idx_q == LW'(i)) begin
        x_sel = x_q[i];
        w_sel = w_q[i];
      end
    end
  end

  assign prod     = x_sel * w_sel;
  assign prod_ext = ACC_W'(prod);
  assign sum      = acc_q + prod_ext;
  // Same-sign operands producing an opposite-sign sum
  assign ovf_now  = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
                    (sum[ACC_W-1] != acc_q[ACC_W-1]);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      acc_q  <= '0;
      idx_q  <= '0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (clear_go) begin
      acc_q  <= '0;
      idx_q  <= '0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (start_go) begin
      acc_q  <= '0;
      idx_q  <= '0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (mac_en) begin
      acc_q <= sum;
      idx_q <= idx_q + LW'(1);
      ovf_q <= ovf_q | ovf_now;
    end else if (fin) begin
      done_q <= 1'b1;
    end
  end

  assign acc64 = 64'(acc_q);

  always_comb begin
    rx = '0;
    rw = '0;
    for (int i = 0; i < VEC_LEN; i++) begin
      if (eidx == LW'(i)) begin
        rx = x_q[i];
        rw = w_q[i];
      end
    end
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      a_ctrl:  rdata = {28'd0, ovf_q, ie_q,
                        done_q, busy};
      a_len:   rdata = 32'(len_q);
      a_lo:    rdata = acc64[31:0];
      a_hi:    rdata = acc64[63:32];
      a_x:     rdata = 32'(rx);
      a_w:     rdata = 32'(rw);
      default: rdata = '0;
    endcase
  end

  assign HRDATA = rd_q ? rdata : 32'd0;

endmodule

// File: tb/tb_ahb_ml_mac_acc.sv
// Directed bench for ahb_ml_mac_acc: register access, MAC timing,
// sign handling, clamping, busy-drop, clear/abort and overflow.
module tb_ahb_ml_mac_acc;

  logic        clk;
  logic        rst_n;
  logic        hsel;
  logic        hready;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic        hwrite;
  logic [31:0] haddr;
  logic [31:0] hwdata;

  logic        rdy1, rdy2;
  logic [1:0]  resp1, resp2;
  logic [31:0] rd1, rd2;
  logic        irq1, irq2;

  int total = 0;
  int bad   = 0;

  logic [31:0] d1, d2;

  ahb_ml_mac_acc #(.DATA_W(16), .VEC_LEN(8), .ACC_W(40)) dut (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel), .HREADY(hready),
    .HTRANS(htrans), .HSIZE(hsize), .HWRITE(hwrite),
    .HADDR(haddr), .HWDATA(hwdata), .HREADYOUT(rdy1),
    .HRESP(resp1), .HRDATA(rd1), .IRQ(irq1)
  );

  ahb_ml_mac_acc #(.DATA_W(16), .VEC_LEN(8), .ACC_W(32)) dut32 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel), .HREADY(hready),
    .HTRANS(htrans), .HSIZE(hsize), .HWRITE(hwrite),
    .HADDR(haddr), .HWDATA(hwdata), .HREADYOUT(rdy2),
    .HRESP(resp2), .HRDATA(rd2), .IRQ(irq2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    hsel   = 1'b0;
    htrans = 2'b00;
    hwrite = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1;
    haddr = {24'd0, a};
    @(posedge clk); #1;
    idle();
    hwdata = d;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] o1,
                    output logic [31:0] o2);
    @(posedge clk); #1;
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0;
    haddr = {24'd0, a};
    @(posedge clk); #1;
    idle();
    o1 = rd1;
    o2 = rd2;
  endtask

  // Called in the START data-phase cycle; reads CTRL every cycle
  task automatic watch(input int len, input string tag);
    logic [31:0] e;
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0;
    haddr = 32'h0;
    for (int k = 1; k <= len + 2; k++) begin
      @(posedge clk); #1;
      e = (k <= len + 1) ? 32'd1 : 32'd2;
      chk($sformatf("%s_st%0d", tag, k), rd1 & 32'h3, e);
    end
    idle();
  endtask

  initial begin
    rst_n  = 1'b0;
    hready = 1'b1;
    hsize  = 3'b010;
    haddr  = '0;
    hwdata = '0;
    idle();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hrdata", rd1, 32'd0);
    chk("rst_readyout", {31'd0, rdy1}, 32'd1);
    chk("rst_hresp", {30'd0, resp1}, 32'd0);
    chk("rst_irq", {31'd0, irq1}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    rd(8'h00, d1, d2); chk("rst_ctrl", d1, 32'd0);
    rd(8'h04, d1, d2); chk("rst_len", d1, 32'd0);
    rd(8'h08, d1, d2); chk("rst_lo", d1, 32'd0);
    rd(8'h0C, d1, d2); chk("rst_hi", d1, 32'd0);
    rd(8'h40, d1, d2); chk("rst_x0", d1, 32'd0);
    rd(8'h9C, d1, d2); chk("rst_w7", d1, 32'd0);

    for (int i = 0; i < 8; i++) begin
      wr(8'h40 + 8'(4 * i), 32'(i + 1));
      wr(8'h80 + 8'(4 * i), 32'(i + 1));
    end
    wr(8'h04, 32'd8);
    rd(8'h4C, d1, d2); chk("x3", d1, 32'd4);
    rd(8'h20, d1, d2); chk("unmapped", d1, 32'd0);
    wr(8'h00, 32'h1);
    watch(8, "t2");
    rd(8'h08, d1, d2); chk("t2_lo", d1, 32'd204);
    chk("t2_lo32", d2, 32'd204);
    rd(8'h0C, d1, d2); chk("t2_hi", d1, 32'd0);
    rd(8'h00, d1, d2); chk("t2_ctrl", d1, 32'h2);

    wr(8'h40, 32'h0000FFFD);
    wr(8'h80, 32'd5);
    wr(8'h04, 32'd1);
    wr(8'h00, 32'h5);
    watch(1, "t3");
    chk("t3_irq", {31'd0, irq1}, 32'd1);
    rd(8'h08, d1, d2); chk("t3_lo", d1, 32'hFFFFFFF1);
    rd(8'h0C, d1, d2); chk("t3_hi", d1, 32'hFFFFFFFF);
    rd(8'h40, d1, d2); chk("t3_x0sext", d1, 32'hFFFFFFFD);
    rd(8'h00, d1, d2); chk("t3_ctrl", d1, 32'h6);
    wr(8'h00, 32'h6);
    rd(8'h00, d1, d2); chk("t3_clr_ctrl", d1, 32'h4);
    chk("t3_clr_irq", {31'd0, irq1}, 32'd0);
    rd(8'h08, d1, d2); chk("t3_clr_lo", d1, 32'd0);
    wr(8'h00, 32'h0);

    wr(8'h00, 32'h1);
    watch(1, "t4a");
    wr(8'h04, 32'd20);
    rd(8'h04, d1, d2); chk("t4_clamp", d1, 32'd8);
    wr(8'h04, 32'd0);
    wr(8'h00, 32'h1);
    watch(0, "t4b");
    rd(8'h08, d1, d2); chk("t4_lo", d1, 32'd0);
    rd(8'h0C, d1, d2); chk("t4_hi", d1, 32'd0);

    wr(8'h04, 32'd8);
    wr(8'h00, 32'h1);
    wr(8'h40, 32'd9);
    wr(8'h04, 32'd3);
    rd(8'h00, d1, d2); chk("t5_busy", d1 & 32'h3, 32'h1);
    wr(8'h00, 32'h2);
    rd(8'h00, d1, d2); chk("t5_ctrl", d1, 32'h0);
    rd(8'h08, d1, d2); chk("t5_lo", d1, 32'd0);
    rd(8'h40, d1, d2); chk("t5_x0", d1, 32'hFFFFFFFD);
    rd(8'h04, d1, d2); chk("t5_len", d1, 32'd8);

    for (int i = 0; i < 8; i++) begin
      wr(8'h40 + 8'(4 * i), 32'h7FFF);
      wr(8'h80 + 8'(4 * i), 32'h7FFF);
    end
    wr(8'h00, 32'h1);
    watch(8, "t6");
    rd(8'h08, d1, d2);
    chk("t6_lo40", d1, 32'hFFF80008);
    chk("t6_lo32", d2, 32'hFFF80008);
    rd(8'h0C, d1, d2);
    chk("t6_hi40", d1, 32'h1);
    chk("t6_hi32", d2, 32'hFFFFFFFF);
    rd(8'h00, d1, d2);
    chk("t6_ctrl40", d1, 32'h2);
    chk("t6_ctrl32", d2, 32'hA);

    wr(8'h00, 32'h1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t7_hrdata", rd1, 32'd0);
    chk("t7_irq", {31'd0, irq1}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rd(8'h00, d1, d2); chk("t7_ctrl", d1, 32'd0);
    rd(8'h04, d1, d2); chk("t7_len", d1, 32'd0);
    rd(8'h40, d1, d2); chk("t7_x0", d1, 32'd0);
    rd(8'h08, d1, d2); chk("t7_lo", d1, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
